// File: rtl/fetch_defs_pkg.sv
// Shared constants, field ranges and FSM encoding for the instruction-fetch stage.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package fetch_defs;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_INS_W  = 16;

  // Opcode field of an instruction word
  localparam int OP_HI = 15;
  localparam int OP_LO = 9;
  localparam int OP_W  = OP_HI - OP_LO + 1;

  localparam logic [OP_W-1:0]       DEF_HALT_OP  = 7'h7F;
  localparam logic [DEF_ADDR_W-1:0] DEF_RESET_PC = 8'h00;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_perf_ctr.sv
// Saturating event counter; sticks at all-ones instead of wrapping.
// Latency: count reflects an increment one cycle after i_inc is sampled high.
// Backpressure: none, counts every cycle i_inc is high.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset (clears the count)
//   i_inc       count one event this cycle
//   o_count     current count
module fetch_perf_ctr #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_inc && !(&r_count)) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register, IR latch with valid/ready handoff, branch flush, halt/resume.
// Latency: instruction at PC appears on ir_out one cycle after it is fetched; 1 instr/cycle sustained.
// Backpressure: ir_valid && !ir_ready holds PC and IR; a branch flushes the IR regardless of ready.
// Configuration: define FETCH_PERF_EN to build the fetch/stall counters; otherwise they read 0.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   pc_addr / ins_in      instruction memory address / combinational read data
//   ir_out, ir_pc         latched instruction and the address it came from
//   ir_valid / ir_ready   handshake to the decoder
//   br_taken, br_target   redirect pulse and new PC
//   resume / halted       leave HALT / HALT indication
//   perf_fetch/perf_stall fetched-instruction and back-pressure cycle counts
import fetch_defs::*;

module fetch_unit #(
  parameter int                ADDR_W   = DEF_ADDR_W,
  parameter int                INS_W    = DEF_INS_W,
  parameter logic [ADDR_W-1:0] RESET_PC = DEF_RESET_PC,
  parameter logic [OP_W-1:0]   HALT_OP  = DEF_HALT_OP
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc_addr,
  input  logic [INS_W-1:0]  ins_in,
  output logic [INS_W-1:0]  ir_out,
  output logic [ADDR_W-1:0] ir_pc,
  output logic              ir_valid,
  input  logic              ir_ready,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              resume,
  output logic              halted,
  output logic [15:0]       perf_fetch,
  output logic [15:0]       perf_stall
);

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [INS_W-1:0]  r_ir;
  logic [ADDR_W-1:0] r_ir_pc;
  logic              r_ir_valid;
  logic              w_fire;
  logic              w_halt_op;

  // A redirect suppresses the fetch in the same cycle; otherwise fetch when the IR is free or draining.
  assign w_fire    = (r_state == ST_RUN) && !br_taken && (!r_ir_valid || ir_ready);
  assign w_halt_op = (ins_in[OP_HI:OP_LO] == HALT_OP);

  // PC / IR datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_ir       <= '0;
      r_ir_pc    <= '0;
      r_ir_valid <= 1'b0;
    end else if (br_taken) begin
      r_pc       <= br_target;
      r_ir_valid <= 1'b0;
    end else if (w_fire) begin
      r_ir       <= ins_in;
      r_ir_pc    <= r_pc;
      r_ir_valid <= 1'b1;
      r_pc       <= r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
    end else if (r_ir_valid && ir_ready) begin
      r_ir_valid <= 1'b0;
    end
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM: next state. The halt instruction itself is still delivered; fetch stops after it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN:  if (w_fire && w_halt_op) w_state_nxt = ST_HALT;
      ST_HALT: if (resume)              w_state_nxt = ST_RUN;
      default: w_state_nxt = ST_RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    halted = (r_state == ST_HALT);
  end

  assign pc_addr  = r_pc;
  assign ir_out   = r_ir;
  assign ir_pc    = r_ir_pc;
  assign ir_valid = r_ir_valid;

`ifdef FETCH_PERF_EN
  logic w_stall_inc;
  assign w_stall_inc = (r_state == ST_RUN) && r_ir_valid && !ir_ready && !br_taken;

  fetch_perf_ctr #(.W(16)) u_perf_fetch (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_fire),
    .o_count (perf_fetch)
  );

  fetch_perf_ctr #(.W(16)) u_perf_stall (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_inc   (w_stall_inc),
    .o_count (perf_stall)
  );
`else
  assign perf_fetch = 16'h0000;
  assign perf_stall = 16'h0000;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instruction memory model.
// Latency: n/a.
// Backpressure: bench drives ir_ready directly.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc_addr;
  logic [15:0] ins_in;
  logic [15:0] ir_out;
  logic [7:0]  ir_pc;
  logic        ir_valid;
  logic        ir_ready;
  logic        br_taken;
  logic [7:0]  br_target;
  logic        resume;
  logic        halted;
  logic [15:0] perf_fetch;
  logic [15:0] perf_stall;
  logic        halt_at10;

  int n_assert;
  int n_fail;

  fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pc_addr    (pc_addr),
    .ins_in     (ins_in),
    .ir_out     (ir_out),
    .ir_pc      (ir_pc),
    .ir_valid   (ir_valid),
    .ir_ready   (ir_ready),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .resume     (resume),
    .halted     (halted),
    .perf_fetch (perf_fetch),
    .perf_stall (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: fields a%6, a%6+1, a%6+2; optional halt word at address 10
  function automatic logic [15:0] mem_word(input logic [7:0] a);
    logic [2:0] m;
    m = 3'(a % 6);
    return {7'h00, 3'(m + 3'd2), 3'(m + 3'd1), m};
  endfunction

  always_comb begin
    ins_in = mem_word(pc_addr);
    if (halt_at10 && pc_addr == 8'h10) ins_in = 16'hFE00;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_assert  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    ir_ready  = 1'b0;
    br_taken  = 1'b0;
    br_target = 8'h00;
    resume    = 1'b0;
    halt_at10 = 1'b0;

    // Reset values
    #12;
    chk("rst_pc", 32'(pc_addr), 32'h00);
    chk("rst_valid", 32'(ir_valid), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_ir", 32'(ir_out), 32'h0000);
    chk("rst_irpc", 32'(ir_pc), 32'h00);
    chk("rst_perf_f", 32'(perf_fetch), 32'h0);
    chk("rst_perf_s", 32'(perf_stall), 32'h0);
    rst_n    = 1'b1;
    ir_ready = 1'b1;

    // Streaming, one per cycle
    tick();
    chk("s0_ir", 32'(ir_out), 32'h0088);
    chk("s0_irpc", 32'(ir_pc), 32'h00);
    chk("s0_valid", 32'(ir_valid), 32'h1);
    chk("s0_pc", 32'(pc_addr), 32'h01);
    tick();
    chk("s1_ir", 32'(ir_out), 32'h00D1);
    chk("s1_irpc", 32'(ir_pc), 32'h01);
    chk("s1_pc", 32'(pc_addr), 32'h02);
    tick();
    tick();
    tick();
    chk("s4_ir", 32'(ir_out), 32'h01AC);
    chk("s4_irpc", 32'(ir_pc), 32'h04);
    chk("s4_pc", 32'(pc_addr), 32'h05);

    // Back-pressure for 3 cycles: everything frozen
    ir_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_ir", 32'(ir_out), 32'h01AC);
      chk("stall_irpc", 32'(ir_pc), 32'h04);
      chk("stall_pc", 32'(pc_addr), 32'h05);
      chk("stall_valid", 32'(ir_valid), 32'h1);
    end
`ifdef FETCH_PERF_EN
    chk("perf_stall3", 32'(perf_stall), 32'd3);
    chk("perf_fetch5", 32'(perf_fetch), 32'd5);
`else
    chk("perf_stall_off", 32'(perf_stall), 32'd0);
`endif
    ir_ready = 1'b1;
    tick();
    chk("s5_ir", 32'(ir_out), 32'h01F5);
    chk("s5_irpc", 32'(ir_pc), 32'h05);
    chk("s5_pc", 32'(pc_addr), 32'h06);

    // Branch to FE with ready high: flush, then wrap FE, FF, 00
    br_taken  = 1'b1;
    br_target = 8'hFE;
    tick();
    chk("br_valid", 32'(ir_valid), 32'h0);
    chk("br_pc", 32'(pc_addr), 32'hFE);
    br_taken = 1'b0;
    tick();
    chk("fe_ir", 32'(ir_out), 32'h011A);
    chk("fe_irpc", 32'(ir_pc), 32'hFE);
    chk("fe_pc", 32'(pc_addr), 32'hFF);
    tick();
    chk("ff_ir", 32'(ir_out), 32'h0163);
    chk("ff_irpc", 32'(ir_pc), 32'hFF);
    chk("wrap_pc", 32'(pc_addr), 32'h00);
    tick();
    chk("w0_ir", 32'(ir_out), 32'h0088);
    chk("w0_irpc", 32'(ir_pc), 32'h00);

    // Branch while IR is held: pending instruction is dropped
    ir_ready  = 1'b0;
    br_taken  = 1'b1;
    br_target = 8'h0E;
    tick();
    chk("drop_valid", 32'(ir_valid), 32'h0);
    chk("drop_pc", 32'(pc_addr), 32'h0E);
    br_taken = 1'b0;
    tick();
    chk("drop_irpc", 32'(ir_pc), 32'h0E);
    chk("drop_ir", 32'(ir_out), 32'h011A);
    chk("drop_valid2", 32'(ir_valid), 32'h1);

    // Halt word at 10, then resume
    halt_at10 = 1'b1;
    ir_ready  = 1'b1;
    tick();
    chk("h0f_irpc", 32'(ir_pc), 32'h0F);
    chk("h0f_halted", 32'(halted), 32'h0);
    tick();
    chk("halt_ir", 32'(ir_out), 32'hFE00);
    chk("halt_irpc", 32'(ir_pc), 32'h10);
    chk("halt_pc", 32'(pc_addr), 32'h11);
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_valid", 32'(ir_valid), 32'h1);
    tick();
    chk("drain_valid", 32'(ir_valid), 32'h0);
    chk("drain_pc", 32'(pc_addr), 32'h11);
    tick();
    chk("hold_pc", 32'(pc_addr), 32'h11);
    chk("hold_halted", 32'(halted), 32'h1);
    resume = 1'b1;
    tick();
    resume = 1'b0;
    chk("res_halted", 32'(halted), 32'h0);
    chk("res_pc", 32'(pc_addr), 32'h11);
    chk("res_valid", 32'(ir_valid), 32'h0);
    tick();
    chk("res_ir", 32'(ir_out), 32'h01F5);
    chk("res_irpc", 32'(ir_pc), 32'h11);
    chk("res_pc2", 32'(pc_addr), 32'h12);
`ifdef FETCH_PERF_EN
    chk("perf_fetch13", 32'(perf_fetch), 32'd13);
    chk("perf_stall_end", 32'(perf_stall), 32'd3);
`else
    chk("perf_fetch_off", 32'(perf_fetch), 32'd0);
`endif

    // Asynchronous reset mid-stream, away from the clock edge
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_pc", 32'(pc_addr), 32'h00);
    chk("arst_valid", 32'(ir_valid), 32'h0);
    chk("arst_halted", 32'(halted), 32'h0);
    chk("arst_ir", 32'(ir_out), 32'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
